bin2bcd_seq: RTL and testbench

Sequential 32-bit binary to 8-digit packed-BCD converter using shift-and-add-3 (double dabble), one input bit per cycle. It sits directly upstream of the dual 4-digit seven-segment display driver and feeds its 32-bit BCD `digits` input. Its own input is a binary value from the CPU debug path, such as a register or PC value. The output digits are registered and held stable between conversions, so the display never shows intermediate values.

---
 rtl/bin2bcd_seq_pkg.sv | 14 +
 rtl/bin2bcd_seq_if.sv | 34 +++
 rtl/bcd_add3.sv | 15 +
 rtl/bin2bcd_seq.sv | 98 +++++++++
 tb/tb_bin2bcd_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared display constants for the binary-to-BCD converter and the digit driver.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_DIGITS = 8;
  localparam int unsigned BCD_W      = 32;
  localparam logic [31:0] BCD_MAX    = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT    = 32'h9999_9999;

  // Converter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the debug path and the BCD converter.
interface bin2bcd_seq_if
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W      = BCD_W,
  parameter int unsigned NUM_DIGITS = BCD_DIGITS
);

  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_W-1:0]        value;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    ovf;
  logic                    done;

  modport master (
    output in_valid,
    output value,
    input  in_ready,
    input  digits,
    input  ovf,
    input  done
  );

  modport slave (
    input  in_valid,
    input  value,
    output in_ready,
    output digits,
    output ovf,
    output done
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  // Correct one BCD digit ahead of the left shift
  always_comb begin
    dout_c = din;
    if (din >= 4'd5) begin
      dout_c = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter, one input bit per cycle, saturating.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W      = BCD_W,
  parameter int unsigned NUM_DIGITS = BCD_DIGITS
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   io
);

  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_sr;
  logic [DIG_W-1:0] bcd_sr;
  logic [DIG_W-1:0] bcd_adj_c;
  logic             ovf_pend;
  logic [DIG_W-1:0] digits_q;
  logic             ovf_q;
  logic             done_q;
  logic             accept_c;
  logic             last_c;

  assign accept_c = (state == ST_IDLE) && io.in_valid;
  assign last_c   = (cnt == CNT_W'(BIN_W - 1));

  // Per-digit add-3 correction on the current BCD accumulator
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din    (bcd_sr[4*g +: 4]),
      .dout_c (bcd_adj_c[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept_c) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_c)   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Shift-and-add-3 datapath; top-digit carries only occur on saturating inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else if (accept_c) begin
      bin_sr   <= io.value;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf_pend <= (io.value > BIN_W'(BCD_MAX));
    end else if (state == ST_SHIFT) begin
      {bcd_sr, bin_sr} <= {bcd_adj_c[DIG_W-2:0], bin_sr, 1'b0};
      cnt              <= cnt + CNT_W'(1);
    end
  end

  // Result registers: updated only on commit, so the display never sees partial values
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (state == ST_DONE) begin
        digits_q <= ovf_pend ? DIG_W'(BCD_SAT) : bcd_sr;
        ovf_q    <= ovf_pend;
      end
    end
  end

  assign io.in_ready = (state == ST_IDLE);
  assign io.digits   = digits_q;
  assign io.ovf      = ovf_q;
  assign io.done     = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal reference model.
module tb_bin2bcd_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] cur_digits;
  logic        cur_ovf;

  bin2bcd_seq_if bus ();

  bin2bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: divide by ten per digit, saturate above eight digits
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0]     r;
    longint unsigned n;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    n = longint'(v);
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion from the current idle/done cycle; optionally keep requesting nv while busy
  task automatic conv(input string tag, input logic [31:0] v, input bit hold, input logic [31:0] nv);
    int          bad;
    logic [31:0] exp_d;
    logic        exp_o;
    exp_d = ref_bcd(v);
    exp_o = (v > 32'd99_999_999);
    bad   = 0;
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.value    = v;
    step();
    if (hold) bus.value = nv;
    else      bus.in_valid = 1'b0;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b0) bad++;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (bus.done !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.digits !== cur_digits || bus.ovf !== cur_ovf) bad++;
    end
    check({tag, "_busy"}, 64'(bad), 64'd0);
    step();
    check({tag, "_done"},   64'(bus.done),     64'd1);
    check({tag, "_digits"}, 64'(bus.digits),   64'(exp_d));
    check({tag, "_ovf"},    64'(bus.ovf),      64'(exp_o));
    check({tag, "_rdy2"},   64'(bus.in_ready), 64'd1);
    cur_digits = exp_d;
    cur_ovf    = exp_o;
  endtask

  initial begin
    int          bad;
    logic [31:0] rv;
    n_cmp        = 0;
    n_err        = 0;
    cur_digits   = '0;
    cur_ovf      = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.value    = 32'd5;

    // Reset held two cycles with a request pending: nothing may start
    step();
    step();
    check("rst_digits", 64'(bus.digits),   64'd0);
    check("rst_ovf",    64'(bus.ovf),      64'd0);
    check("rst_done",   64'(bus.done),     64'd0);
    check("rst_ready",  64'(bus.in_ready), 64'd1);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_done",  64'(bus.done),     64'd0);

    // Main example and boundaries, issued back to back
    conv("ex",      32'd12_345_678,  1'b0, 32'd0);
    step();
    check("done_pulse", 64'(bus.done), 64'd0);
    conv("zero",    32'd0,           1'b0, 32'd0);
    conv("five",    32'd5,           1'b0, 32'd0);
    conv("ten",     32'd10,          1'b0, 32'd0);
    conv("max",     32'd99_999_999,  1'b0, 32'd0);
    conv("ovf1",    32'd100_000_000, 1'b0, 32'd0);
    conv("allones", 32'hFFFF_FFFF,   1'b0, 32'd0);
    conv("back",    32'd7,           1'b0, 32'd0);

    // Busy: request held high with 77 is captured in the done cycle
    conv("busy42",  32'd42, 1'b1, 32'd77);
    conv("busy77",  32'd77, 1'b0, 32'd0);
    check("busy77_val", 64'(bus.digits), 64'h77);

    // Reset ten cycles into a conversion
    bus.in_valid = 1'b1;
    bus.value    = 32'd12_345_678;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_digits", 64'(bus.digits),   64'd0);
    check("mid_ovf",    64'(bus.ovf),      64'd0);
    check("mid_ready",  64'(bus.in_ready), 64'd1);
    cur_digits = '0;
    cur_ovf    = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.digits !== 32'd0) bad++;
    end
    check("mid_nodone", 64'(bad), 64'd0);
    conv("after_rst", 32'd9, 1'b0, 32'd0);

    // Randomized in-range values, plus a few unrestricted ones
    for (int i = 0; i < 16; i++) begin
      rv = 32'($urandom_range(0, 99_999_999));
      conv("rand", rv, 1'b0, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      rv = $urandom();
      conv("rand32", rv, 1'b0, 32'd0);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
